// File: rtl/copperv_read_arbiter_pkg.sv
// copperv_read_arbiter_pkg: shared constants for the copperv read-port arbiter.
// Holds the FSM state encoding, the grant identities and the default bus width.
package copperv_read_arbiter_pkg;

    localparam int BUS_WIDTH       = 32;
    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_STATE_IDLE    = 2'd0,
        ARB_STATE_ADDR    = 2'd1,
        ARB_STATE_RESP    = 2'd2,
        ARB_STATE_DELIVER = 2'd3
    } arb_state_t;

    localparam logic ARB_GRANT_INST = 1'b0;
    localparam logic ARB_GRANT_DATA = 1'b1;

endpackage

// File: rtl/copperv_read_arbiter_if.sv
// copperv_read_arbiter_if: bundles the instruction-read, data-read and memory
// valid/ready channels. The arbiter uses the slave modport; the core/memory
// environment uses the master modport.
interface copperv_read_arbiter_if #(
    parameter int bus_width = 32
);
    logic                 ir_addr_valid;
    logic                 ir_addr_ready;
    logic [bus_width-1:0] ir_addr;
    logic                 ir_data_valid;
    logic                 ir_data_ready;
    logic [bus_width-1:0] ir_data;

    logic                 dr_addr_valid;
    logic                 dr_addr_ready;
    logic [bus_width-1:0] dr_addr;
    logic                 dr_data_valid;
    logic                 dr_data_ready;
    logic [bus_width-1:0] dr_data;

    logic                 m_addr_valid;
    logic                 m_addr_ready;
    logic [bus_width-1:0] m_addr;
    logic                 m_data_valid;
    logic                 m_data_ready;
    logic [bus_width-1:0] m_data;

    modport slave (
        input  ir_addr_valid, ir_addr, ir_data_ready,
        output ir_addr_ready, ir_data_valid, ir_data,
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        output m_addr_valid, m_addr, m_data_ready,
        input  m_addr_ready, m_data_valid, m_data
    );

    modport master (
        output ir_addr_valid, ir_addr, ir_data_ready,
        input  ir_addr_ready, ir_data_valid, ir_data,
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        input  m_addr_valid, m_addr, m_data_ready,
        output m_addr_ready, m_data_valid, m_data
    );

endinterface

// File: rtl/copperv_arb_pick.sv
// copperv_arb_pick: combinational winner selection between the instruction
// and data read requesters. Configuration macro: COPPERV_ARB_ROUND_ROBIN_EN
// (defined: ties alternate away from last_grant; undefined: data wins ties).
module copperv_arb_pick
    import copperv_read_arbiter_pkg::*;
(
    input  logic ir_addr_valid,
    input  logic dr_addr_valid,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

`ifndef COPPERV_ARB_ROUND_ROBIN_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
`endif

    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
        any_req = ir_addr_valid | dr_addr_valid;
        grant   = ARB_GRANT_INST;
        if (ir_addr_valid && dr_addr_valid) begin
`ifdef COPPERV_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = ARB_GRANT_DATA;
`endif
        end else if (dr_addr_valid) begin
            grant = ARB_GRANT_DATA;
        end
    end

endmodule

// File: rtl/copperv_read_arbiter.sv
// copperv_read_arbiter: shares one memory read port between the instruction
// and data read channels, one transaction in flight at a time.
// Configuration macro: COPPERV_ARB_ROUND_ROBIN_EN selects round-robin ties
// (otherwise fixed priority, data first).
module copperv_read_arbiter
    import copperv_read_arbiter_pkg::*;
#(
    parameter int bus_width = BUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    copperv_read_arbiter_if.slave   bus
);

    arb_state_t           r_state;
    logic                 r_grant_q;
    logic [bus_width-1:0] r_addr_q;
    logic [bus_width-1:0] r_data_q;
    logic                 r_m_addr_valid;
    logic                 r_m_data_ready;
    logic                 r_ir_data_valid;
    logic                 r_dr_data_valid;

    logic w_grant;
    logic w_any_req;
    logic w_last_grant;
    logic w_idle;
    logic w_accept;

    assign w_idle   = (r_state == ARB_STATE_IDLE);
    assign w_accept = w_idle && w_any_req;

`ifdef COPPERV_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Remember every accepted winner so the next tie goes the other way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= ARB_GRANT_DATA;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = ARB_GRANT_DATA;
`endif

    copperv_arb_pick u_pick (
        .ir_addr_valid (bus.ir_addr_valid),
        .dr_addr_valid (bus.dr_addr_valid),
        .last_grant    (w_last_grant),
        .grant         (w_grant),
        .any_req       (w_any_req)
    );

    // Address acceptance is combinational in IDLE; gating with rst keeps it
    // low while reset is held even if a requester is already waiting.
    assign bus.ir_addr_ready = rst && w_accept && (w_grant == ARB_GRANT_INST);
    assign bus.dr_addr_ready = rst && w_accept && (w_grant == ARB_GRANT_DATA);

    assign bus.m_addr_valid  = r_m_addr_valid;
    assign bus.m_addr        = r_addr_q;
    assign bus.m_data_ready  = r_m_data_ready;
    assign bus.ir_data_valid = r_ir_data_valid;
    assign bus.dr_data_valid = r_dr_data_valid;
    assign bus.ir_data       = r_data_q;
    assign bus.dr_data       = r_data_q;

    // Transaction FSM: accept, present address, collect data, hand it back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ARB_STATE_IDLE;
            r_grant_q       <= ARB_GRANT_INST;
            r_addr_q        <= '0;
            r_data_q        <= '0;
            r_m_addr_valid  <= 1'b0;
            r_m_data_ready  <= 1'b0;
            r_ir_data_valid <= 1'b0;
            r_dr_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ARB_STATE_IDLE: begin
                    if (w_any_req) begin
                        r_grant_q      <= w_grant;
                        r_addr_q       <= (w_grant == ARB_GRANT_DATA) ? bus.dr_addr : bus.ir_addr;
                        r_m_addr_valid <= 1'b1;
                        r_state        <= ARB_STATE_ADDR;
                    end
                end
                ARB_STATE_ADDR: begin
                    if (bus.m_addr_ready) begin
                        r_m_addr_valid <= 1'b0;
                        r_m_data_ready <= 1'b1;
                        r_state        <= ARB_STATE_RESP;
                    end
                end
                ARB_STATE_RESP: begin
                    if (bus.m_data_valid) begin
                        r_data_q        <= bus.m_data;
                        r_m_data_ready  <= 1'b0;
                        r_ir_data_valid <= (r_grant_q == ARB_GRANT_INST);
                        r_dr_data_valid <= (r_grant_q == ARB_GRANT_DATA);
                        r_state         <= ARB_STATE_DELIVER;
                    end
                end
                ARB_STATE_DELIVER: begin
                    if ((r_grant_q == ARB_GRANT_DATA) ? bus.dr_data_ready : bus.ir_data_ready) begin
                        r_ir_data_valid <= 1'b0;
                        r_dr_data_valid <= 1'b0;
                        r_state         <= ARB_STATE_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// tb_copperv_read_arbiter: self-checking bench for copperv_read_arbiter.
// Honours COPPERV_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_copperv_read_arbiter;

    localparam int BW = 32;

`ifdef COPPERV_ARB_ROUND_ROBIN_EN
    localparam bit TIE_D = 1'b0;
`else
    localparam bit TIE_D = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    copperv_read_arbiter_if #(.bus_width(BW)) bus ();

    copperv_read_arbiter #(.bus_width(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory model ----------------
    int          addr_wait = 0;
    int          data_wait = 0;
    bit          mem_rand  = 1'b0;
    bit          rnd_ar    = 1'b0;
    bit          rnd_dv    = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    int          aw_cnt = 0;
    int          dw_cnt = 0;
    logic [31:0] mem_lat = 32'h0;

    always @(posedge clk) begin
        if (bus.m_addr_valid && !bus.m_addr_ready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
        if (bus.m_data_ready && !bus.m_data_valid) dw_cnt <= dw_cnt + 1; else dw_cnt <= 0;
        if (bus.m_addr_valid && bus.m_addr_ready) mem_lat <= bus.m_addr;
    end

    assign bus.m_addr_ready = mem_rand ? rnd_ar : (aw_cnt >= addr_wait);
    assign bus.m_data_valid = mem_rand ? rnd_dv : (dw_cnt >= data_wait);
    assign bus.m_data       = use_fixed ? fixed_data : mem_lat + 32'd1;

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          who;
        logic [31:0] val;
        int          cyc;
    } ev_t;
    ev_t acc_q[$];
    ev_t dlv_q[$];

    // transaction tracker of the reference model
    bit          out = 0, macc = 0, ret = 0, who = 0, tb_last = 1;
    bit          hs_ir = 0, hs_dr = 0;
    logic [31:0] t_addr = 0, t_data = 0;

    // driver controls applied at posedge+1
    bit          nx_rst = 0, clr = 0, rand_mode = 0;
    bit          nx_ir_drdy = 1, nx_dr_drdy = 1;
    bit          q_ir = 0, q_dr = 0;
    logic [31:0] q_ir_addr = 0, q_dr_addr = 0;
    int          stream_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit winner(input bit iv, input bit dv);
        if (iv && dv) begin
`ifdef COPPERV_ARB_ROUND_ROBIN_EN
            return !tb_last;
`else
            return 1'b1;
`endif
        end
        return dv;
    endfunction

    // Reference model: checks this cycle's outputs, then advances the
    // transaction tracker from the bench's own expectations.
    task automatic monitor();
        bit e_ir, e_dr, w;
        ev_t e;
        hs_ir = 0;
        hs_dr = 0;
        if (!rst) begin
            chk("rst_ctrl", {26'd0, bus.m_addr_valid, bus.m_data_ready, bus.ir_addr_ready,
                             bus.dr_addr_ready, bus.ir_data_valid, bus.dr_data_valid}, 32'd0);
            chk("rst_bus", bus.ir_data | bus.dr_data | bus.m_addr, 32'd0);
            out = 0; macc = 0; ret = 0; tb_last = 1;
            return;
        end
        chk("m_addr_valid", {31'd0, bus.m_addr_valid}, {31'd0, out && !macc});
        if (out && !macc) chk("m_addr", bus.m_addr, t_addr);
        chk("m_data_ready", {31'd0, bus.m_data_ready}, {31'd0, out && macc && !ret});
        chk("ir_data_valid", {31'd0, bus.ir_data_valid}, {31'd0, out && ret && !who});
        chk("dr_data_valid", {31'd0, bus.dr_data_valid}, {31'd0, out && ret && who});
        if (out && ret) chk("resp_data", who ? bus.dr_data : bus.ir_data, t_data);
        e_ir = 0;
        e_dr = 0;
        if (!out && (bus.ir_addr_valid || bus.dr_addr_valid)) begin
            w    = winner(bus.ir_addr_valid, bus.dr_addr_valid);
            e_ir = !w;
            e_dr = w;
        end
        chk("ir_addr_ready", {31'd0, bus.ir_addr_ready}, {31'd0, e_ir});
        chk("dr_addr_ready", {31'd0, bus.dr_addr_ready}, {31'd0, e_dr});
        if (e_ir || e_dr) begin
            who     = e_dr;
            t_addr  = e_dr ? bus.dr_addr : bus.ir_addr;
            t_data  = use_fixed ? fixed_data : t_addr + 32'd1;
            out     = 1; macc = 0; ret = 0;
            tb_last = e_dr;
            hs_ir   = e_ir;
            hs_dr   = e_dr;
            e.who = who; e.val = t_addr; e.cyc = cyc;
            acc_q.push_back(e);
        end else if (out && !macc) begin
            if (bus.m_addr_ready) macc = 1;
        end else if (out && !ret) begin
            if (bus.m_data_valid) ret = 1;
        end else if (out) begin
            if (who ? bus.dr_data_ready : bus.ir_data_ready) begin
                out = 0;
                e.who = who; e.val = who ? bus.dr_data : bus.ir_data; e.cyc = cyc;
                dlv_q.push_back(e);
            end
        end
    endtask

    // One clock: drive at posedge+1, check at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = nx_rst;
        if (clr) begin
            bus.ir_addr_valid = 0; bus.dr_addr_valid = 0; stream_left = 0; clr = 0;
        end
        if (hs_ir) begin
            if (stream_left > 0) stream_left--;
            if (stream_left > 0) bus.ir_addr = bus.ir_addr + 32'd4;
            else bus.ir_addr_valid = 0;
        end
        if (hs_dr) bus.dr_addr_valid = 0;
        if (q_ir) begin bus.ir_addr_valid = 1; bus.ir_addr = q_ir_addr; q_ir = 0; end
        if (q_dr) begin bus.dr_addr_valid = 1; bus.dr_addr = q_dr_addr; q_dr = 0; end
        if (rand_mode) begin
            if (!bus.ir_addr_valid) begin
                if ($urandom_range(0, 3) == 0) begin bus.ir_addr_valid = 1; bus.ir_addr = $urandom; end
            end else if ($urandom_range(0, 3) == 0) bus.ir_addr = $urandom;
            if (!bus.dr_addr_valid) begin
                if ($urandom_range(0, 3) == 0) begin bus.dr_addr_valid = 1; bus.dr_addr = $urandom; end
            end else if ($urandom_range(0, 3) == 0) bus.dr_addr = $urandom;
            bus.ir_data_ready = ($urandom_range(0, 2) != 0);
            bus.dr_data_ready = ($urandom_range(0, 2) != 0);
            rnd_ar = ($urandom_range(0, 2) != 0);
            rnd_dv = ($urandom_range(0, 2) != 0);
        end else begin
            bus.ir_data_ready = nx_ir_drdy;
            bus.dr_data_ready = nx_dr_drdy;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        nx_rst = 0;
        clr    = 1;
        step();
        step();
        nx_rst = 1;
        step();
        acc_q.delete();
        dlv_q.delete();
    endtask

    task automatic run_until_dlv(input int n, input int maxc);
        int k;
        k = 0;
        while (dlv_q.size() < n && k < maxc) begin
            step();
            k++;
        end
        chk("dlv_count", dlv_q.size(), n);
    endtask

    typedef struct {
        bit          iv;
        bit          dv;
        logic [31:0] ia;
        logic [31:0] da;
        bit          er_i;
        bit          er_d;
    } vec_t;
    vec_t tbl[5];

    initial begin
        logic [31:0] ea;
        int          k;

        bus.ir_addr_valid = 0; bus.ir_addr = 0; bus.ir_data_ready = 1;
        bus.dr_addr_valid = 0; bus.dr_addr = 0; bus.dr_data_ready = 1;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1,   1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_0200, 1'b0,   1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, !TIE_D, TIE_D};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0030, 32'h0000_0040, 1'b0,   1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, !TIE_D, TIE_D};

        // table-driven single decisions from a fresh reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            q_ir = tbl[i].iv; q_ir_addr = tbl[i].ia;
            q_dr = tbl[i].dv; q_dr_addr = tbl[i].da;
            step();
            chk("tbl_ir_ready", {31'd0, bus.ir_addr_ready}, {31'd0, tbl[i].er_i});
            chk("tbl_dr_ready", {31'd0, bus.dr_addr_ready}, {31'd0, tbl[i].er_d});
            if (tbl[i].er_i || tbl[i].er_d) begin
                run_until_dlv(1, 20);
                if (dlv_q.size() >= 1) begin
                    ea = tbl[i].er_d ? tbl[i].da : tbl[i].ia;
                    chk("tbl_data", dlv_q[0].val, ea + 32'd1);
                    chk("tbl_who", {31'd0, dlv_q[0].who}, {31'd0, tbl[i].er_d});
                    chk("tbl_latency", dlv_q[0].cyc - acc_q[0].cyc, 32'd3);
                end
            end else begin
                step();
                step();
                chk("tbl_idle_mav", {31'd0, bus.m_addr_valid}, 32'd0);
            end
        end

        // single instruction fetch, cycle by cycle
        do_reset();
        use_fixed = 1; fixed_data = 32'hDEAD_BEEF;
        q_ir = 1; q_ir_addr = 32'h100;
        step();
        chk("c0_ir_ready", {31'd0, bus.ir_addr_ready}, 32'd1);
        step();
        chk("c1_m_addr_valid", {31'd0, bus.m_addr_valid}, 32'd1);
        chk("c1_m_addr", bus.m_addr, 32'h100);
        step();
        chk("c2_m_data_ready", {31'd0, bus.m_data_ready}, 32'd1);
        step();
        chk("c3_ir_data_valid", {31'd0, bus.ir_data_valid}, 32'd1);
        chk("c3_ir_data", bus.ir_data, 32'hDEAD_BEEF);
        chk("c3_dr_data_valid", {31'd0, bus.dr_data_valid}, 32'd0);
        step();
        chk("c4_ir_data_valid", {31'd0, bus.ir_data_valid}, 32'd0);
        use_fixed = 0;

        // simultaneous requests, then a second tie
        do_reset();
        for (int r = 0; r < 2; r++) begin
            acc_q.delete();
            dlv_q.delete();
            q_ir = 1; q_ir_addr = 32'h10;
            q_dr = 1; q_dr_addr = 32'h20;
            run_until_dlv(2, 40);
            if (dlv_q.size() >= 2) begin
                chk("tie_first_who", {31'd0, dlv_q[0].who}, {31'd0, TIE_D});
                chk("tie_first_data", dlv_q[0].val, TIE_D ? 32'h21 : 32'h11);
                chk("tie_second_who", {31'd0, dlv_q[1].who}, {31'd0, !TIE_D});
                chk("tie_second_data", dlv_q[1].val, TIE_D ? 32'h11 : 32'h21);
            end
        end

        // memory backpressure: 3 address waits, 2 data waits
        do_reset();
        addr_wait = 3; data_wait = 2;
        q_ir = 1; q_ir_addr = 32'h200;
        run_until_dlv(1, 40);
        if (dlv_q.size() >= 1) begin
            chk("mbp_latency", dlv_q[0].cyc - acc_q[0].cyc, 32'd8);
            chk("mbp_data", dlv_q[0].val, 32'h201);
        end
        addr_wait = 0; data_wait = 0;

        // requester backpressure on the data channel
        do_reset();
        nx_dr_drdy = 0;
        q_dr = 1; q_dr_addr = 32'h40;
        k = 0;
        while (!bus.dr_data_valid && k < 20) begin step(); k++; end
        chk("rbp_dv_seen", {31'd0, bus.dr_data_valid}, 32'd1);
        q_ir = 1; q_ir_addr = 32'h80;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rbp_dr_data", bus.dr_data, 32'h41);
            chk("rbp_ir_ready", {31'd0, bus.ir_addr_ready}, 32'd0);
        end
        nx_dr_drdy = 1;
        run_until_dlv(2, 20);
        if (dlv_q.size() >= 2 && acc_q.size() >= 2) begin
            chk("rbp_ir_accept_who", {31'd0, acc_q[1].who}, 32'd0);
            chk("rbp_ir_accept_cyc", acc_q[1].cyc, dlv_q[0].cyc + 1);
            chk("rbp_ir_data", dlv_q[1].val, 32'h81);
        end

        // asynchronous reset in the middle of RESP
        do_reset();
        data_wait = 6;
        q_ir = 1; q_ir_addr = 32'h300;
        k = 0;
        while (!bus.m_data_ready && k < 10) begin step(); k++; end
        chk("mid_in_resp", {31'd0, bus.m_data_ready}, 32'd1);
        #2;
        rst    = 0;
        nx_rst = 0;
        #1;
        chk("async_m_data_ready", {31'd0, bus.m_data_ready}, 32'd0);
        chk("async_m_addr", bus.m_addr, 32'd0);
        chk("async_data_valid", {30'd0, bus.ir_data_valid, bus.dr_data_valid}, 32'd0);
        data_wait = 0;
        step();
        nx_rst = 1;
        step();
        acc_q.delete();
        dlv_q.delete();
        q_ir = 1; q_ir_addr = 32'h400;
        run_until_dlv(1, 20);
        if (dlv_q.size() >= 1) begin
            chk("post_rst_data", dlv_q[0].val, 32'h401);
            chk("post_rst_latency", dlv_q[0].cyc - acc_q[0].cyc, 32'd3);
        end

        // back-to-back streaming of 8 instruction fetches
        do_reset();
        stream_left = 8;
        q_ir = 1; q_ir_addr = 32'h1000;
        run_until_dlv(8, 60);
        for (int i = 0; i < 8 && i < dlv_q.size(); i++) begin
            chk("stream_data", dlv_q[i].val, 32'h1000 + 32'(4 * i) + 32'd1);
            if (i > 0) chk("stream_gap", dlv_q[i].cyc - dlv_q[i-1].cyc, 32'd4);
        end

        // randomized traffic against the reference model
        do_reset();
        rand_mode = 1;
        mem_rand  = 1;
        repeat (2000) step();
        rand_mode = 0;
        mem_rand  = 0;
        nx_ir_drdy = 1;
        nx_dr_drdy = 1;
        k = 0;
        while ((out || bus.ir_addr_valid || bus.dr_addr_valid) && k < 100) begin step(); k++; end
        chk("rand_drained", {31'd0, out}, 32'd0);
        chk("rand_all_delivered", dlv_q.size(), acc_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
